// File: rtl/game_countdown_ctrl_pkg.sv
// game_countdown_ctrl_pkg: shared timer state encodings and default frame rate
package game_countdown_ctrl_pkg;
  typedef enum logic [1:0] {
    TMR_IDLE   = 2'b00,
    TMR_RUN    = 2'b01,
    TMR_PAUSED = 2'b10,
    TMR_DONE   = 2'b11
  } tmr_state_t;
  localparam int DEF_TICK_HZ = 60;
endpackage

// File: rtl/game_mmss_update.sv
// game_mmss_update: mm:ss plus add minus dec with single carry/borrow, no divider
module game_mmss_update
  import game_countdown_ctrl_pkg::*;
#(
  parameter int MIN_W = 4
) (
  input  logic [MIN_W-1:0] minutes,
  input  logic [5:0]       seconds,
  input  logic [5:0]       add,
  input  logic             dec,
  output logic [MIN_W-1:0] minutes_next,
  output logic [5:0]       seconds_next
);
  logic [7:0] s;
  always_comb begin
    s = {2'b00, seconds} + {2'b00, add} - {7'b0, dec};
    seconds_next = s[7] ? 6'd59 : s >= 8'd60 ? 6'(s - 8'd60) : s[5:0];
    minutes_next = s[7] ? minutes - MIN_W'(1) : s >= 8'd60 ? minutes + MIN_W'(1) : minutes;
  end
endmodule

// File: rtl/game_countdown_ctrl.sv
// game_countdown_ctrl: frame-tick countdown with pause, bonus add, warn/blink and mm:ss
module game_countdown_ctrl
  import game_countdown_ctrl_pkg::*;
#(
  parameter int TICK_HZ   = DEF_TICK_HZ,
  parameter int START_SEC = 180,
  parameter int MAX_SEC   = 599,
  parameter int WARN_SEC  = 10,
  parameter int SEC_W     = 10,
  parameter int MIN_W     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             timer_start,
  input  logic             timer_pause,
  input  logic             timer_tick,
  input  logic             bonus_valid,
  input  logic [5:0]       bonus_sec,
  output logic [1:0]       timer_state,
  output logic [SEC_W-1:0] sec_left,
  output logic [MIN_W-1:0] minutes,
  output logic [5:0]       seconds,
  output logic             timer_warn,
  output logic             timer_blink,
  output logic             timer_done,
  output logic             done_pulse,
  output logic             bonus_drop
);
  localparam int FW = $clog2(TICK_HZ + 1);
  localparam logic [FW-1:0] FRAME_TOP = FW'(TICK_HZ - 1);
  localparam logic [MIN_W-1:0] START_MIN = MIN_W'(START_SEC / 60);
  localparam logic [5:0] START_S = 6'(START_SEC % 60);
  localparam bit START_WARN = START_SEC <= WARN_SEC;
  localparam bit START_BLINK = START_WARN && (TICK_HZ - 1 >= TICK_HZ / 2);
  tmr_state_t state, state_nx;
  logic [FW-1:0] frame_cnt, frame_nx;
  logic run, live, step, dec, try_bonus, drop, warn_nx;
  logic [SEC_W:0] sum;
  logic [5:0] add, s_nx;
  logic [SEC_W-1:0] sec_nx;
  logic [MIN_W-1:0] min_nx;
  assign timer_state = state;
  always_comb begin
    run = state == TMR_RUN;
    live = run || state == TMR_PAUSED;
    step = run && !timer_pause && timer_tick;
    dec = step && frame_cnt == '0;
    frame_nx = step ? (dec ? FRAME_TOP : frame_cnt - FW'(1)) : frame_cnt;
    try_bonus = live && bonus_valid && bonus_sec != '0;
    sum = {1'b0, sec_left} + (SEC_W+1)'(bonus_sec) - (SEC_W+1)'(dec);
    drop = try_bonus && sum > (SEC_W+1)'(MAX_SEC);
    add = try_bonus && !drop ? bonus_sec : '0;
    sec_nx = sec_left + SEC_W'(add) - SEC_W'(dec);
    state_nx = run ? (timer_pause ? TMR_PAUSED : sec_nx == '0 ? TMR_DONE : TMR_RUN)
             : (state == TMR_PAUSED && !timer_pause) ? TMR_RUN : state;
    warn_nx = (state_nx == TMR_RUN || state_nx == TMR_PAUSED) && sec_nx <= SEC_W'(WARN_SEC);
  end
  game_mmss_update #(.MIN_W(MIN_W)) u_mmss (
    .minutes(minutes),
    .seconds(seconds),
    .add(add),
    .dec(dec),
    .minutes_next(min_nx),
    .seconds_next(s_nx)
  );
  always_ff @(posedge clk) begin
    if (!reset_n || timer_start) begin
      state <= reset_n ? TMR_RUN : TMR_IDLE;
      sec_left <= SEC_W'(START_SEC);
      minutes <= START_MIN;
      seconds <= START_S;
      frame_cnt <= FRAME_TOP;
      timer_warn <= reset_n && START_WARN;
      timer_blink <= reset_n && START_BLINK;
      timer_done <= 1'b0;
      done_pulse <= 1'b0;
      bonus_drop <= 1'b0;
    end else begin
      state <= state_nx;
      sec_left <= sec_nx;
      minutes <= min_nx;
      seconds <= s_nx;
      frame_cnt <= frame_nx;
      timer_warn <= warn_nx;
      timer_blink <= warn_nx && frame_nx >= FW'(TICK_HZ / 2);
      timer_done <= state_nx == TMR_DONE;
      done_pulse <= run && state_nx == TMR_DONE;
      bonus_drop <= drop;
    end
  end
endmodule

// File: tb/tb_game_countdown_ctrl.sv
// tb_game_countdown_ctrl: table vectors, corner sequences and random run against a model
module tb_game_countdown_ctrl;
  localparam int TH = 4;
  localparam int SS = 3;
  localparam int MX = 65;
  localparam int WS = 2;
  typedef struct {
    logic st, pa, ti, bv;
    logic [5:0] bs;
    int sec, stt;
    logic pul, drp;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n, timer_start, timer_pause, timer_tick, bonus_valid;
  logic [5:0] bonus_sec;
  logic [1:0] timer_state, d_state;
  logic [9:0] sec_left, d_sec;
  logic [3:0] minutes, d_min;
  logic [5:0] seconds, d_s;
  logic timer_warn, timer_blink, timer_done, done_pulse, bonus_drop;
  logic d_warn, d_blink, d_done, d_pulse, d_drop;
  int checks = 0;
  int errors = 0;
  int m_state, m_sec, m_fc;
  logic m_pulse, m_drop, m_warn, m_blink;
  vec_t tbl[$];
  game_countdown_ctrl #(.TICK_HZ(TH), .START_SEC(SS), .MAX_SEC(MX), .WARN_SEC(WS), .SEC_W(10), .MIN_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .timer_start(timer_start), .timer_pause(timer_pause),
    .timer_tick(timer_tick), .bonus_valid(bonus_valid), .bonus_sec(bonus_sec),
    .timer_state(timer_state), .sec_left(sec_left), .minutes(minutes), .seconds(seconds),
    .timer_warn(timer_warn), .timer_blink(timer_blink), .timer_done(timer_done),
    .done_pulse(done_pulse), .bonus_drop(bonus_drop)
  );
  game_countdown_ctrl dut_def (
    .clk(clk), .reset_n(reset_n), .timer_start(timer_start), .timer_pause(timer_pause),
    .timer_tick(timer_tick), .bonus_valid(bonus_valid), .bonus_sec(bonus_sec),
    .timer_state(d_state), .sec_left(d_sec), .minutes(d_min), .seconds(d_s),
    .timer_warn(d_warn), .timer_blink(d_blink), .timer_done(d_done),
    .done_pulse(d_pulse), .bonus_drop(d_drop)
  );
  initial forever #5 clk = ~clk;
  function automatic vec_t v(logic st, pa, ti, bv, logic [5:0] bs, int sec, stt, logic pul, drp);
    vec_t r;
    r.st = st; r.pa = pa; r.ti = ti; r.bv = bv; r.bs = bs;
    r.sec = sec; r.stt = stt; r.pul = pul; r.drp = drp;
    return r;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_step(input logic rn, st, pa, ti, bv, input int bs);
    int d = 0;
    int a = 0;
    m_pulse = 1'b0;
    m_drop = 1'b0;
    if (!rn || st) begin
      m_state = rn ? 1 : 0;
      m_sec = SS;
      m_fc = TH - 1;
    end else begin
      if (m_state == 1 && !pa && ti) begin
        if (m_fc == 0) begin
          m_fc = TH - 1;
          d = 1;
        end else m_fc--;
      end
      if ((m_state == 1 || m_state == 2) && bv && bs != 0) begin
        if (m_sec + bs - d > MX) m_drop = 1'b1;
        else a = bs;
      end
      m_sec = m_sec + a - d;
      if (m_state == 1) begin
        if (pa) m_state = 2;
        else if (m_sec == 0) begin
          m_state = 3;
          m_pulse = 1'b1;
        end
      end else if (m_state == 2 && !pa) m_state = 1;
    end
    m_warn = (m_state == 1 || m_state == 2) && m_sec > 0 && m_sec <= WS;
    m_blink = m_warn && m_fc >= TH / 2;
  endtask
  task automatic check_all();
    chk("state", int'(timer_state), m_state);
    chk("sec_left", int'(sec_left), m_sec);
    chk("minutes", int'(minutes), m_sec / 60);
    chk("seconds", int'(seconds), m_sec % 60);
    chk("warn", int'(timer_warn), int'(m_warn));
    chk("blink", int'(timer_blink), int'(m_blink));
    chk("done", int'(timer_done), int'(m_state == 3));
    chk("done_pulse", int'(done_pulse), int'(m_pulse));
    chk("bonus_drop", int'(bonus_drop), int'(m_drop));
  endtask
  task automatic cyc(input logic rn, st, pa, ti, bv, input logic [5:0] bs);
    reset_n = rn; timer_start = st; timer_pause = pa; timer_tick = ti;
    bonus_valid = bv; bonus_sec = bs;
    @(posedge clk);
    model_step(rn, st, pa, ti, bv, int'(bs));
    #1;
    check_all();
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 1, 0, 0);
  endtask
  initial begin
    tbl.push_back(v(1, 0, 0, 0, 0, 3, 1, 0, 0));
    for (int k = 1; k <= 12; k++) tbl.push_back(v(0, 0, 1, 0, 0, 3 - k / 4, k == 12 ? 3 : 1, k == 12, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 3, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 7, 0, 3, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 3, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 57, 60, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 6, 60, 1, 0, 1));
    tbl.push_back(v(0, 0, 0, 1, 5, 65, 1, 0, 0));
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 5);
    chk("reset_state", int'(timer_state), 0);
    chk("reset_sec", int'(sec_left), 3);
    chk("reset_frame_flags", int'({timer_warn, timer_blink, timer_done, done_pulse, bonus_drop}), 0);
    foreach (tbl[i]) begin
      cyc(1, tbl[i].st, tbl[i].pa, tbl[i].ti, tbl[i].bv, tbl[i].bs);
      chk($sformatf("vec%0d_sec", i), int'(sec_left), tbl[i].sec);
      chk($sformatf("vec%0d_state", i), int'(timer_state), tbl[i].stt);
      chk($sformatf("vec%0d_pulse", i), int'(done_pulse), int'(tbl[i].pul));
      chk($sformatf("vec%0d_drop", i), int'(bonus_drop), int'(tbl[i].drp));
    end
    chk("mmss_105", int'({minutes, seconds}), int'({4'd1, 6'd5}));
    cyc(1, 1, 0, 0, 0, 0);
    ticks(4);
    chk("t2_warn", int'(timer_warn), 1);
    chk("t2_blink_fc3", int'(timer_blink), 1);
    ticks(1);
    chk("t2_blink_fc2", int'(timer_blink), 1);
    ticks(1);
    chk("t2_blink_fc1", int'(timer_blink), 0);
    cyc(1, 0, 1, 1, 0, 0);
    chk("t2_paused", int'(timer_state), 2);
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, 1, 0, 0);
    chk("t2_hold_sec", int'(sec_left), 2);
    cyc(1, 0, 0, 0, 0, 0);
    chk("t2_resume", int'(timer_state), 1);
    ticks(1);
    chk("t2_partial", int'(sec_left), 2);
    ticks(1);
    chk("t2_sec1", int'(sec_left), 1);
    chk("t2_blink_reload", int'(timer_blink), 1);
    cyc(1, 1, 0, 0, 0, 0);
    ticks(11);
    chk("t5_pre_sec", int'(sec_left), 1);
    cyc(1, 0, 0, 1, 1, 10);
    chk("t5_sec", int'(sec_left), 10);
    chk("t5_no_done", int'({timer_done, done_pulse}), 0);
    chk("t5_state", int'(timer_state), 1);
    cyc(1, 1, 0, 0, 0, 0);
    ticks(5);
    chk("t6_pre_sec", int'(sec_left), 2);
    cyc(1, 1, 0, 1, 1, 9);
    chk("t6_start_sec", int'(sec_left), 3);
    ticks(3);
    chk("t6_reload_hold", int'(sec_left), 3);
    ticks(1);
    chk("t6_reload_dec", int'(sec_left), 2);
    ticks(2);
    cyc(0, 0, 0, 1, 1, 3);
    chk("t6_rst_state", int'(timer_state), 0);
    chk("t6_rst_mmss", int'({minutes, seconds}), int'({4'd0, 6'd3}));
    chk("t6_rst_flags", int'({timer_warn, timer_blink, timer_done, done_pulse, bonus_drop}), 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("t3_start_min", int'(d_min), 3);
    chk("t3_start_s", int'(d_s), 0);
    for (int k = 1; k <= 3660; k++) begin
      ticks(1);
      if (k % 60 == 0) begin
        chk("t3_sec", int'(d_sec), 180 - k / 60);
        chk("t3_min", int'(d_min), (180 - k / 60) / 60);
        chk("t3_s", int'(d_s), (180 - k / 60) % 60);
      end
    end
    chk("t3_min_159", int'(d_min), 1);
    chk("t3_s_159", int'(d_s), 59);
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, 6'($urandom_range(0, 59)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
